// File: rtl/adc_sched_pkg.sv
// adc_sched_pkg: shared state encoding, sizes and channel helpers for the ADC scan scheduler
package adc_sched_pkg;
    localparam int NUM_CH = 13;
    localparam int SDI_WORD_BITS = 12;
    localparam int CFG_BITS = 6;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CONVST,
        ST_CONV_WAIT,
        ST_SHIFT,
        ST_SETTLE,
        ST_FLUSH_DONE
    } state_t;

    function automatic logic [2:0] mux_sel(input logic [3:0] ch);
        logic [3:0] d;
        d = ch - 4'd6;
        return d[2:0];
    endfunction

    // First enabled channel after cur, ascending with wrap; cur itself if no other is enabled
    function automatic logic [3:0] next_ch(input logic [NUM_CH-1:0] mask, input logic [3:0] cur);
        logic [3:0] c;
        logic [3:0] n;
        logic found;
        c = cur;
        n = cur;
        found = 1'b0;
        for (int i = 1; i < NUM_CH; i++) begin
            c = (c == 4'(NUM_CH - 1)) ? 4'd0 : c + 4'd1;
            if (!found && mask[c]) begin
                n = c;
                found = 1'b1;
            end
        end
        return n;
    endfunction
endpackage

// File: rtl/adc_sck_gen.sv
// adc_sck_gen: gated serial clock burst of N periods, high half first, with edge and done strobes
module adc_sck_gen #(
    parameter int CLK_DIV = 2,
    parameter int N = 12
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    output logic sck,
    output logic rise,
    output logic fall,
    output logic done
);
    logic active;
    logic [15:0] div;
    logic [5:0] half;
    logic tick;

    assign tick = active && div == 16'(CLK_DIV - 1);
    assign done = tick && half == 6'(2 * N - 1);
    assign rise = start || (tick && half[0] && !done);
    assign fall = tick && !half[0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active <= 1'b0;
            sck <= 1'b0;
            div <= '0;
            half <= '0;
        end else if (start) begin
            active <= 1'b1;
            sck <= 1'b1;
            div <= '0;
            half <= '0;
        end else if (tick) begin
            div <= '0;
            half <= half + 6'd1;
            sck <= half[0] && !done;
            active <= !done;
        end else if (active) begin
            div <= div + 16'd1;
        end
    end
endmodule

// File: rtl/adc_scan_scheduler.sv
// adc_scan_scheduler: round-robin conversion sequencer for the serial ADC and external 8:1 mux
module adc_scan_scheduler
    import adc_sched_pkg::*;
#(
    parameter int CLK_DIV = 2,
    parameter int CONV_CYCLES = 80,
    parameter int SETTLE_CYCLES = 16,
    parameter logic [NUM_CH-1:0] OS_TABLE = 13'b0111111010101,
    parameter logic [NUM_CH-1:0] S1_TABLE = 13'b0111111111000,
    parameter logic [NUM_CH-1:0] S0_TABLE = 13'b0111111100110,
    parameter logic UNI = 1'b1,
    parameter logic SLP = 1'b0
) (
    input  logic CLOCK_50,
    input  logic RESET_N,
    input  logic RUN,
    input  logic [NUM_CH-1:0] CH_MASK,
    input  logic ADC_SDO,
    output logic ADC_CONVST,
    output logic ADC_SCK,
    output logic ADC_SDI,
    output logic [2:0] MUX_CONTROL,
    output logic [11:0] DATA,
    output logic [3:0] DATA_CH,
    output logic DATA_VALID,
    output logic BUSY
);
    state_t state;
    logic [15:0] cnt;
    logic [3:0] ch, prev_ch, cfg_ch;
    logic pend, flush, stop;
    logic [SDI_WORD_BITS-1:0] sdi_sr, sdo_sr, cfg_word;
    logic sck_start, sck_rise, sck_fall, sck_done;

    assign stop = !RUN || CH_MASK == '0;
    assign sck_start = state == ST_CONV_WAIT && cnt == 16'(CONV_CYCLES - 1);
    assign cfg_ch = flush ? 4'd0 : ch;
    assign cfg_word = {1'b1, OS_TABLE[cfg_ch], S1_TABLE[cfg_ch], S0_TABLE[cfg_ch], UNI, SLP,
                       {(SDI_WORD_BITS - CFG_BITS){1'b1}}};
    assign ADC_SDI = sdi_sr[SDI_WORD_BITS-1];
    assign BUSY = state != ST_IDLE;

    adc_sck_gen #(.CLK_DIV(CLK_DIV), .N(SDI_WORD_BITS)) u_sck (
        .clk(CLOCK_50),
        .rst_n(RESET_N),
        .start(sck_start),
        .sck(ADC_SCK),
        .rise(sck_rise),
        .fall(sck_fall),
        .done(sck_done)
    );

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            state <= ST_IDLE;
            cnt <= '0;
            ch <= '0;
            prev_ch <= '0;
            pend <= 1'b0;
            flush <= 1'b0;
            sdi_sr <= '1;
            sdo_sr <= '0;
            ADC_CONVST <= 1'b0;
            MUX_CONTROL <= '0;
            DATA <= '0;
            DATA_CH <= '0;
            DATA_VALID <= 1'b0;
        end else begin
            DATA_VALID <= 1'b0;
            if (sck_rise) sdo_sr <= {sdo_sr[SDI_WORD_BITS-2:0], ADC_SDO};
            if (sck_fall) sdi_sr <= {sdi_sr[SDI_WORD_BITS-2:0], 1'b1};
            case (state)
                ST_IDLE: if (!stop) begin
                    ch <= next_ch(CH_MASK, 4'(NUM_CH - 1));
                    ADC_CONVST <= 1'b1;
                    cnt <= '0;
                    state <= ST_CONVST;
                end
                ST_CONVST: if (cnt == 16'd1) begin
                    ADC_CONVST <= 1'b0;
                    cnt <= '0;
                    sdi_sr <= cfg_word;
                    state <= ST_CONV_WAIT;
                end else cnt <= cnt + 16'd1;
                ST_CONV_WAIT: if (sck_start) state <= ST_SHIFT; else cnt <= cnt + 16'd1;
                // Word shifted now belongs to the channel configured one frame earlier
                ST_SHIFT: if (sck_done) begin
                    if (pend) begin
                        DATA <= sdo_sr;
                        DATA_CH <= prev_ch;
                        DATA_VALID <= 1'b1;
                    end
                    pend <= !flush;
                    prev_ch <= ch;
                    cnt <= '0;
                    state <= flush ? ST_FLUSH_DONE : ST_SETTLE;
                end
                ST_SETTLE: begin
                    if (cnt == 16'd0) begin
                        if (ch >= 4'd6 && ch <= 4'd11) MUX_CONTROL <= mux_sel(ch);
                        ch <= next_ch(CH_MASK, ch);
                    end
                    if (cnt == 16'(SETTLE_CYCLES - 1)) begin
                        cnt <= '0;
                        flush <= stop;
                        ADC_CONVST <= !stop || pend;
                        state <= (!stop || pend) ? ST_CONVST : ST_IDLE;
                    end else cnt <= cnt + 16'd1;
                end
                ST_FLUSH_DONE: begin
                    flush <= 1'b0;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_adc_scan_scheduler.sv
// tb_adc_scan_scheduler: directed scenarios against two scheduler instances (CLK_DIV=2 and CLK_DIV=1)
module tb_adc_scan_scheduler;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic run = 1'b0, run1 = 1'b0;
    logic [12:0] mask = '0, mask1 = '0;
    logic sdo = 1'b0, sdo1 = 1'b0;
    logic convst, sck, sdi, dv, busy;
    logic convst1, sck1, sdi1, dv1, busy1;
    logic [2:0] mux, mux1;
    logic [11:0] data, data1;
    logic [3:0] dch, dch1;
    logic [11:0] pat = '0, pat1 = '0;

    int n_cmp = 0, n_err = 0, cyc = 0;
    int cs_cyc[$], cs_mux[$], dv_cyc[$];
    logic [11:0] dv_data[$], words[$];
    logic [3:0] dv_ch[$];
    int busy_fall = -1;
    int cs1_cyc[$], rc1[$], dv1_cyc[$];
    logic [11:0] dv1_data[$];
    logic [3:0] dv1_ch[$];
    int sdo_idx = 0, sdo1_idx = 0, rise_cnt = 0, rise1_cnt = 0;
    logic [11:0] sdi_cap = '0;
    logic convst_q = 1'b0, busy_q = 1'b0, convst1_q = 1'b0;

    adc_scan_scheduler dut (
        .CLOCK_50(clk), .RESET_N(rst_n), .RUN(run), .CH_MASK(mask), .ADC_SDO(sdo),
        .ADC_CONVST(convst), .ADC_SCK(sck), .ADC_SDI(sdi), .MUX_CONTROL(mux),
        .DATA(data), .DATA_CH(dch), .DATA_VALID(dv), .BUSY(busy)
    );

    adc_scan_scheduler #(.CLK_DIV(1)) dut1 (
        .CLOCK_50(clk), .RESET_N(rst_n), .RUN(run1), .CH_MASK(mask1), .ADC_SDO(sdo1),
        .ADC_CONVST(convst1), .ADC_SCK(sck1), .ADC_SDI(sdi1), .MUX_CONTROL(mux1),
        .DATA(data1), .DATA_CH(dch1), .DATA_VALID(dv1), .BUSY(busy1)
    );

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (convst && !convst_q) begin
            cs_cyc.push_back(cyc);
            cs_mux.push_back(int'(mux));
        end
        if (dv) begin
            dv_cyc.push_back(cyc);
            dv_data.push_back(data);
            dv_ch.push_back(dch);
        end
        if (!busy && busy_q) busy_fall <= cyc;
        if (convst1 && !convst1_q) cs1_cyc.push_back(cyc);
        if (dv1) begin
            dv1_cyc.push_back(cyc);
            dv1_data.push_back(data1);
            dv1_ch.push_back(dch1);
        end
        convst_q <= convst;
        busy_q <= busy;
        convst1_q <= convst1;
    end

    // ADC model: MSB ready after CONVST, next bit presented after each SCK fall
    always @(posedge convst) begin
        sdo_idx = 0;
        sdo = pat[11];
        rise_cnt = 0;
    end
    always @(negedge sck) begin
        sdo_idx++;
        sdo = sdo_idx < 12 ? pat[11-sdo_idx] : 1'b0;
    end
    always @(posedge sck) begin
        sdi_cap = {sdi_cap[10:0], sdi};
        rise_cnt++;
        if (rise_cnt == 12) words.push_back(sdi_cap);
    end
    always @(posedge convst1) begin
        if (rise1_cnt != 0) rc1.push_back(rise1_cnt);
        rise1_cnt = 0;
        sdo1_idx = 0;
        sdo1 = pat1[11];
    end
    always @(negedge sck1) begin
        sdo1_idx++;
        sdo1 = sdo1_idx < 12 ? pat1[11-sdo1_idx] : 1'b0;
    end
    always @(posedge sck1) rise1_cnt++;

    task automatic clear_q();
        cs_cyc.delete(); cs_mux.delete(); dv_cyc.delete(); dv_data.delete();
        dv_ch.delete(); words.delete(); busy_fall = -1;
    endtask

    task automatic wait_idle(input int lim, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < lim; i++) begin
            @(negedge clk);
            if (!busy) begin ok = 1'b1; break; end
        end
    endtask

    task automatic wait_cs(input int lim, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < lim; i++) begin
            @(negedge clk);
            if (convst) begin ok = 1'b1; break; end
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({convst, sck, sdi, mux, data, dch, dv, busy} !== {3'b001, 3'd0, 12'd0, 4'd0, 2'b00}) begin
            n_err++;
            $display("FAIL reset_idle: got cs=%b sck=%b sdi=%b mux=%0d data=%h ch=%0d dv=%b busy=%b required 0 0 1 0 000 0 0 0",
                     convst, sck, sdi, mux, data, dch, dv, busy);
        end
        n_cmp++;
        if ({convst1, sck1, sdi1, mux1, data1, dch1, dv1, busy1} !== {3'b001, 3'd0, 12'd0, 4'd0, 2'b00}) begin
            n_err++;
            $display("FAIL reset_idle_div1: got cs=%b sck=%b sdi=%b busy=%b required 0 0 1 0", convst1, sck1, sdi1, busy1);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_single();
        int t0;
        bit ok;
        clear_q();
        @(negedge clk);
        pat = 12'hA5C; mask = 13'h0001; run = 1'b1; t0 = cyc;
        repeat (600) @(negedge clk);
        run = 1'b0;
        wait_idle(400, ok);
        n_cmp++;
        if (!ok) begin n_err++; $display("FAIL single_idle: busy=%b required 0", busy); end
        n_cmp++;
        if (cs_cyc.size() != 6 || dv_cyc.size() != 5 || words.size() != 6) begin
            n_err++;
            $display("FAIL single_counts: convst=%0d dv=%0d words=%0d required 6 5 6", cs_cyc.size(), dv_cyc.size(), words.size());
        end else begin
            n_cmp++;
            if (cs_cyc[0] - t0 !== 1) begin n_err++; $display("FAIL single_start: got %0d required 1", cs_cyc[0] - t0); end
            n_cmp++;
            if (cs_cyc[1] - cs_cyc[0] !== 146) begin n_err++; $display("FAIL single_period: got %0d required 146", cs_cyc[1] - cs_cyc[0]); end
            n_cmp++;
            if (dv_cyc[0] - cs_cyc[0] !== 276) begin n_err++; $display("FAIL single_first_dv: got %0d required 276", dv_cyc[0] - cs_cyc[0]); end
            n_cmp++;
            if (dv_cyc[1] - dv_cyc[0] !== 146) begin n_err++; $display("FAIL single_dv_period: got %0d required 146", dv_cyc[1] - dv_cyc[0]); end
            for (int i = 0; i < 5; i++) begin
                n_cmp++;
                if (dv_data[i] !== 12'hA5C || dv_ch[i] !== 4'd0) begin
                    n_err++;
                    $display("FAIL single_data%0d: got %h/ch%0d required a5c/ch0", i, dv_data[i], dv_ch[i]);
                end
            end
            n_cmp++;
            if (words[0] !== 12'hCBF) begin n_err++; $display("FAIL single_sdi_word: got %h required cbf", words[0]); end
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        @(negedge clk);
        mask = 13'h0001; run = 1'b1;
        wait_cs(5, ok);
        n_cmp++;
        if (!ok) begin n_err++; $display("FAIL rstmid_start: convst=%b required 1", convst); end
        repeat (100) @(negedge clk);
        n_cmp++;
        if ({busy, sdi} !== 2'b10) begin n_err++; $display("FAIL rstmid_pre: busy/sdi=%b%b required 10", busy, sdi); end
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({sck, sdi, convst, busy, dv} !== 5'b01000) begin
            n_err++;
            $display("FAIL rstmid_async: sck=%b sdi=%b cs=%b busy=%b dv=%b required 0 1 0 0 0", sck, sdi, convst, busy, dv);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({convst, busy, mux} !== {2'b11, 3'd0}) begin
            n_err++;
            $display("FAIL rstmid_restart: cs=%b busy=%b mux=%0d required 1 1 0", convst, busy, mux);
        end
        run = 1'b0;
        wait_idle(400, ok);
        n_cmp++;
        if (!ok) begin n_err++; $display("FAIL rstmid_idle: busy=%b required 0", busy); end
    endtask

    task automatic test_empty();
        int bad, t0;
        bit ok;
        clear_q();
        @(negedge clk);
        mask = '0; run = 1'b1; bad = 0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (convst || busy) bad++;
        end
        n_cmp++;
        if (bad !== 0) begin n_err++; $display("FAIL empty_mask: active cycles %0d required 0", bad); end
        mask = 13'h1000; t0 = cyc;
        wait_cs(5, ok);
        n_cmp++;
        if (!ok || cyc - t0 !== 1) begin n_err++; $display("FAIL empty_wake: latency %0d ok=%b required 1", cyc - t0, ok); end
        run = 1'b0;
        wait_idle(400, ok);
        n_cmp++;
        if (!ok || words.size() == 0 || words[0] !== 12'h8BF) begin
            n_err++;
            $display("FAIL empty_ch12_word: ok=%b words=%0d first=%h required 8bf", ok, words.size(), words.size() ? words[0] : 12'h0);
        end
    endtask

    task automatic test_stop();
        int c0;
        bit ok;
        logic [11:0] exp_w [4] = '{12'hFBF, 12'hFBF, 12'hFBF, 12'hCBF};
        int exp_mux [4] = '{0, 3, 5, 3};
        logic [3:0] exp_ch [3] = '{4'd9, 4'd11, 4'd9};
        clear_q();
        @(negedge clk);
        pat = 12'h5A3; mask = 13'h0A00; run = 1'b1;
        wait_cs(5, ok);
        c0 = cyc;
        repeat (2 * 146 + 10) @(negedge clk);
        run = 1'b0;
        repeat (600) @(negedge clk);
        n_cmp++;
        if (!ok || cs_cyc.size() != 4 || dv_cyc.size() != 3 || words.size() != 4) begin
            n_err++;
            $display("FAIL stop_counts: convst=%0d dv=%0d words=%0d required 4 3 4", cs_cyc.size(), dv_cyc.size(), words.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                n_cmp++;
                if (words[i] !== exp_w[i] || cs_mux[i] !== exp_mux[i]) begin
                    n_err++;
                    $display("FAIL stop_frame%0d: word %h mux %0d required %h mux %0d", i, words[i], cs_mux[i], exp_w[i], exp_mux[i]);
                end
            end
            for (int i = 0; i < 3; i++) begin
                n_cmp++;
                if (dv_ch[i] !== exp_ch[i] || dv_data[i] !== 12'h5A3) begin
                    n_err++;
                    $display("FAIL stop_dv%0d: ch%0d data %h required ch%0d 5a3", i, dv_ch[i], dv_data[i], exp_ch[i]);
                end
            end
            n_cmp++;
            if (busy_fall - c0 !== 569 || busy !== 1'b0) begin
                n_err++;
                $display("FAIL stop_busy_fall: at %0d busy=%b required 569 0", busy_fall - c0, busy);
            end
        end
    endtask

    task automatic test_wrap();
        bit ok;
        logic [11:0] exp_w [4] = '{12'hBBF, 12'hFBF, 12'h8BF, 12'hBBF};
        int exp_mux [4] = '{3, 3, 0, 0};
        logic [3:0] exp_ch [3] = '{4'd5, 4'd6, 4'd12};
        clear_q();
        @(negedge clk);
        pat = 12'h777; mask = 13'h1060; run = 1'b1;
        repeat (600) @(negedge clk);
        run = 1'b0;
        wait_idle(400, ok);
        n_cmp++;
        if (!ok || cs_cyc.size() < 4 || dv_cyc.size() < 3 || words.size() < 4) begin
            n_err++;
            $display("FAIL wrap_counts: ok=%b convst=%0d dv=%0d words=%0d", ok, cs_cyc.size(), dv_cyc.size(), words.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                n_cmp++;
                if (words[i] !== exp_w[i] || cs_mux[i] !== exp_mux[i]) begin
                    n_err++;
                    $display("FAIL wrap_frame%0d: word %h mux %0d required %h mux %0d", i, words[i], cs_mux[i], exp_w[i], exp_mux[i]);
                end
            end
            for (int i = 0; i < 3; i++) begin
                n_cmp++;
                if (dv_ch[i] !== exp_ch[i]) begin
                    n_err++;
                    $display("FAIL wrap_dv%0d: ch%0d required ch%0d", i, dv_ch[i], exp_ch[i]);
                end
            end
        end
    endtask

    task automatic test_clkdiv1();
        bit ok;
        @(negedge clk);
        pat1 = 12'h3C9; mask1 = 13'h0001; run1 = 1'b1;
        repeat (400) @(negedge clk);
        run1 = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (!busy1) begin ok = 1'b1; break; end
        end
        n_cmp++;
        if (!ok || cs1_cyc.size() < 3 || rc1.size() < 2 || dv1_cyc.size() < 2) begin
            n_err++;
            $display("FAIL div1_counts: ok=%b convst=%0d rc=%0d dv=%0d", ok, cs1_cyc.size(), rc1.size(), dv1_cyc.size());
        end else begin
            n_cmp++;
            if (cs1_cyc[1] - cs1_cyc[0] !== 122) begin n_err++; $display("FAIL div1_period: got %0d required 122", cs1_cyc[1] - cs1_cyc[0]); end
            n_cmp++;
            if (rc1[0] !== 12 || rc1[1] !== 12) begin n_err++; $display("FAIL div1_rises: got %0d %0d required 12 12", rc1[0], rc1[1]); end
            n_cmp++;
            if (dv1_cyc[0] - cs1_cyc[0] !== 228) begin n_err++; $display("FAIL div1_first_dv: got %0d required 228", dv1_cyc[0] - cs1_cyc[0]); end
            n_cmp++;
            if (dv1_data[0] !== 12'h3C9 || dv1_ch[0] !== 4'd0 || dv1_data[1] !== 12'h3C9) begin
                n_err++;
                $display("FAIL div1_data: got %h/%h ch%0d required 3c9/3c9 ch0", dv1_data[0], dv1_data[1], dv1_ch[0]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_reset_mid();
        test_empty();
        test_stop();
        test_wrap();
        test_clkdiv1();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
